// File: rtl/pause_detect_unit_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: pause codes,
// opcode values, the slot entry type and the rt-as-source mask helper.
package pause_detect_unit_pkg;

    localparam int          PAUSE_LENGTH = 2;
    localparam logic [1:0]  PAUSE_NO     = 2'b00;
    localparam logic [1:0]  PAUSE_RS     = 2'b01;
    localparam logic [1:0]  PAUSE_RT     = 2'b10;
    localparam logic [1:0]  PAUSE_BOTH   = 2'b11;

    localparam logic [5:0]  OP_SPECIAL   = 6'h00;
    localparam logic [5:0]  OP_BEQ       = 6'h04;
    localparam logic [5:0]  OP_BNE       = 6'h05;
    localparam logic [5:0]  OP_SW        = 6'h2B;

    // One in-flight writer: destination register plus a valid flag.
    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
    } slot_t;

    // rt is a true source only for R-type, the two-register branches and
    // stores; every other opcode uses rt as a destination or branch code.
    function automatic logic rt_is_source(input logic [5:0] opcode);
        return (opcode == OP_SPECIAL) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)     || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/pause_slot_cmp.sv
// Compares one source register against every compared scoreboard slot;
// hit is the OR over all valid slots holding that register (never $0).
module pause_slot_cmp
    import pause_detect_unit_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [4:0]      src,
    input  slot_t [N-1:0]   slots,
    output logic            hit
);

    // OR-reduce matches across slots; duplicates need no special handling.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves hit
        // unassigned, which would otherwise infer a latch.
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (slots[i].valid && (slots[i].wreg == src) && (src != 5'd0)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pause_detect_unit.sv
// ID-stage data-hazard scoreboard. Tracks destinations of in-flight
// writers (slot 0 = EX) and reports which source field of the instruction
// in ID depends on a write that has not yet retired. No forwarding exists,
// so any hit stalls ID until the writer leaves the compare window.
module pause_detect_unit
    import pause_detect_unit_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rt_code,
    input  logic        id_pause,
    input  logic        id_regwe,
    input  logic [4:0]  id_wreg,
    output logic [1:0]  pause_code,
    output logic [31:0] stall_cnt
);

    // With the write-first regfile the WB slot is already visible to ID.
    localparam int CMP_N = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    slot_t [DEPTH-1:0] slots;
    slot_t             push;
    logic              rs_hit;
    logic              rt_cmp_hit;
    logic              rt_hit;

    // A stalled, invalid or non-writing instruction enters as a bubble;
    // writes to $0 are dropped since they can never create a hazard.
    assign push.valid = id_valid & ~id_pause & id_regwe & (id_wreg != 5'd0);
    assign push.wreg  = id_wreg;

    // Shift the scoreboard one stage per unfrozen cycle; hold wins over push.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every slot is reset, not just the valid bits, so a stale
        // wreg can never be observed and the array stays a plain register.
        if (!rst_n) begin
            slots <= '0;
        end else if (!hold) begin
            // NOTE: non-blocking assignments make each stage take the old
            // value of its predecessor, giving a true shift register.
            slots[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Saturating count of cycles the decoder actually spends stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!hold && id_pause && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    pause_slot_cmp #(.N(CMP_N)) u_rs_cmp (
        .src   (id_rs),
        .slots (slots[CMP_N-1:0]),
        .hit   (rs_hit)
    );

    pause_slot_cmp #(.N(CMP_N)) u_rt_cmp (
        .src   (id_rt),
        .slots (slots[CMP_N-1:0]),
        .hit   (rt_cmp_hit)
    );

    assign rt_hit = rt_cmp_hit & rt_is_source(id_opcode);

    // Purely from registered slots and ID fields; id_pause never feeds back.
    assign pause_code = id_valid ? {rt_hit, rs_hit} : PAUSE_NO;

    // id_rt_code mirrors id_rt and exists only for decoder port parity; the
    // oldest slot only matters for compares when WB bypass is disabled.
    logic unused_ok;
    assign unused_ok = ^{id_rt_code, slots[DEPTH-1]};

endmodule

// File: tb/tb_pause_detect_unit.sv
// Directed bench for pause_detect_unit (DEPTH=3, WB_BYPASS=1). The bench
// plays the decoder: it presents ID fields, drives id_pause from its own
// hand-derived stall decision, and checks pause_code / stall_cnt.
module tb_pause_detect_unit;
    import pause_detect_unit_pkg::*;

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rt_code;
    logic        id_pause;
    logic        id_regwe;
    logic [4:0]  id_wreg;
    logic [1:0]  pause_code;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pause_detect_unit #(.DEPTH(3), .WB_BYPASS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rt_code (id_rt_code),
        .id_pause   (id_pause),
        .id_regwe   (id_regwe),
        .id_wreg    (id_wreg),
        .pause_code (pause_code),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Present an instruction in ID and let the combinational path settle.
    task automatic set_id(input logic valid, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] wreg, input logic regwe);
        id_valid   = valid;
        id_opcode  = op;
        id_rs      = rs;
        id_rt      = rt;
        id_rt_code = rt;
        id_wreg    = wreg;
        id_regwe   = regwe;
        #1;
    endtask

    // One clock edge with the given decoder pause; returns 1 after the edge.
    task automatic tick(input logic pause);
        id_pause = pause;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        id_pause = 1'b0;
        set_id(1'b0, OP_SPECIAL, 5'd0, 5'd0, 5'd0, 1'b0);
        check("reset_code", 32'(pause_code), 32'(PAUSE_NO));
        check("reset_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // addu $3,$1,$2 on an empty board.
        set_id(1'b1, OP_SPECIAL, 5'd1, 5'd2, 5'd3, 1'b1);
        check("addu_empty", 32'(pause_code), 32'(PAUSE_NO));
        check("addu_cnt", stall_cnt, 32'd0);
        tick(1'b0);                                   // slots: 3,-,-

        // addiu $5,$0,1 then addu $6,$5,$0: RS for two cycles.
        set_id(1'b1, OP_ADDIU, 5'd0, 5'd5, 5'd5, 1'b1);
        check("addiu_issue", 32'(pause_code), 32'(PAUSE_NO));
        tick(1'b0);                                   // slots: 5,3,-
        set_id(1'b1, OP_SPECIAL, 5'd5, 5'd0, 5'd6, 1'b1);
        check("raw_rs_slot0", 32'(pause_code), 32'(PAUSE_RS));
        tick(1'b1);                                   // slots: b,5,3
        check("raw_rs_slot1", 32'(pause_code), 32'(PAUSE_RS));
        tick(1'b1);                                   // slots: b,b,5
        check("raw_rs_wb_bypass", 32'(pause_code), 32'(PAUSE_NO));
        check("raw_rs_cnt", stall_cnt, 32'd2);
        tick(1'b0);                                   // slots: 6,b,b

        // lw $7,0($1) then sll $8,$7,2: RT while $7 is in slots 0..1.
        set_id(1'b1, OP_LW, 5'd1, 5'd7, 5'd7, 1'b1);
        check("lw_issue", 32'(pause_code), 32'(PAUSE_NO));
        tick(1'b0);                                   // slots: 7,6,b
        set_id(1'b1, OP_SPECIAL, 5'd0, 5'd7, 5'd8, 1'b1);
        check("sll_rt_slot0", 32'(pause_code), 32'(PAUSE_RT));
        tick(1'b1);                                   // slots: b,7,6
        check("sll_rt_slot1", 32'(pause_code), 32'(PAUSE_RT));
        tick(1'b1);                                   // slots: b,b,7
        check("sll_rt_clear", 32'(pause_code), 32'(PAUSE_NO));
        check("sll_cnt", stall_cnt, 32'd4);
        tick(1'b0);                                   // slots: 8,b,b

        // $9 into slot 0, then rt-mask cases.
        set_id(1'b1, OP_ADDIU, 5'd0, 5'd9, 5'd9, 1'b1);
        tick(1'b0);                                   // slots: 9,8,b
        set_id(1'b1, OP_ORI, 5'd9, 5'd9, 5'd9, 1'b1);
        check("ori_rt_masked", 32'(pause_code), 32'(PAUSE_RS));
        set_id(1'b1, OP_SPECIAL, 5'd9, 5'd9, 5'd10, 1'b1);
        check("addu_both", 32'(pause_code), 32'(PAUSE_BOTH));
        set_id(1'b1, OP_SW, 5'd0, 5'd9, 5'd0, 1'b0);
        check("sw_rt", 32'(pause_code), 32'(PAUSE_RT));
        set_id(1'b1, OP_BNE, 5'd9, 5'd0, 5'd0, 1'b0);
        check("bne_rs", 32'(pause_code), 32'(PAUSE_RS));
        set_id(1'b0, OP_SPECIAL, 5'd9, 5'd9, 5'd10, 1'b1);
        check("invalid_forces_no", 32'(pause_code), 32'(PAUSE_NO));

        // Freeze with ori stalled: nothing may move for 4 cycles.
        set_id(1'b1, OP_ORI, 5'd9, 5'd9, 5'd9, 1'b1);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            check("hold_code", 32'(pause_code), 32'(PAUSE_RS));
            check("hold_cnt", stall_cnt, 32'd4);
        end
        hold = 1'b0;
        tick(1'b1);                                   // slots: b,9,8
        check("after_hold_slot1", 32'(pause_code), 32'(PAUSE_RS));
        check("after_hold_cnt", stall_cnt, 32'd5);
        tick(1'b1);                                   // slots: b,b,9
        check("after_hold_clear", 32'(pause_code), 32'(PAUSE_NO));
        check("after_hold_cnt2", stall_cnt, 32'd6);
        tick(1'b0);                                   // slots: 9,b,b

        // Writes to $0 never register; consumers of $0 never stall.
        set_id(1'b1, OP_ADDIU, 5'd0, 5'd0, 5'd0, 1'b1);
        check("w0_issue", 32'(pause_code), 32'(PAUSE_NO));
        tick(1'b0);                                   // slots: -,9,b
        set_id(1'b1, OP_SPECIAL, 5'd0, 5'd0, 5'd11, 1'b1);
        check("r0_no_hazard", 32'(pause_code), 32'(PAUSE_NO));
        tick(1'b0);                                   // slots: 11,-,9

        // Reset in the middle of a stall clears the board asynchronously.
        set_id(1'b1, OP_ADDIU, 5'd0, 5'd12, 5'd12, 1'b1);
        tick(1'b0);                                   // slots: 12,11,-
        set_id(1'b1, OP_SPECIAL, 5'd12, 5'd0, 5'd13, 1'b1);
        check("pre_reset_rs", 32'(pause_code), 32'(PAUSE_RS));
        tick(1'b1);                                   // slots: b,12,11
        check("pre_reset_cnt", stall_cnt, 32'd7);
        check("pre_reset_slot1", 32'(pause_code), 32'(PAUSE_RS));
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_code", 32'(pause_code), 32'(PAUSE_NO));
        check("mid_reset_cnt", stall_cnt, 32'd0);
        #3 rst_n = 1'b1;
        #1;
        check("post_reset_code", 32'(pause_code), 32'(PAUSE_NO));
        tick(1'b0);                                   // slots: 13,-,-
        set_id(1'b1, OP_SPECIAL, 5'd13, 5'd13, 5'd14, 1'b1);
        check("post_reset_resume", 32'(pause_code), 32'(PAUSE_BOTH));
        check("post_reset_cnt", stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so a stuck run still ends with a summary.
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
